// File: rtl/wb_bram_pkg.sv
// ============================================================================
// Module   : wb_bram_pkg
// Brief    : Shared types and defaults for the two-master BRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_bram_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DMA = 1'b1
  } master_e;

  localparam logic [31:0] C_BASE_ADDR = 32'h3800_0000;
  localparam int          C_READ_LAT  = 10;

endpackage

`default_nettype wire

// File: rtl/wb_bram_arb_pick.sv
// ============================================================================
// Module   : wb_bram_arb_pick
// Brief    : Combinational winner select between CPU and DMA requests.
//            WB_BRAM_ARB_RR_EN selects round-robin, otherwise DMA has priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bram_arb_pick
  import wb_bram_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    dma_req_i,
`ifdef WB_BRAM_ARB_RR_EN
  input  master_e last_grant_i,
`endif
  output logic    req_any_o,
  output master_e winner_o
);

  always_comb begin
    req_any_o = cpu_req_i | dma_req_i;
    winner_o  = M_CPU;
`ifdef WB_BRAM_ARB_RR_EN
    // On a tie the master that was not served last goes next
    if (cpu_req_i && dma_req_i) begin
      winner_o = (last_grant_i == M_CPU) ? M_DMA : M_CPU;
    end else if (dma_req_i) begin
      winner_o = M_DMA;
    end
`else
    if (dma_req_i) begin
      winner_o = M_DMA;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/wb_bram_arbiter.sv
// ============================================================================
// Module   : wb_bram_arbiter
// Brief    : Serialises CPU and DMA Wishbone accesses onto one fixed-latency
//            BRAM port. Optional macro WB_BRAM_ARB_RR_EN enables round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bram_arbiter
  import wb_bram_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          READ_LAT  = C_READ_LAT,
  parameter logic [31:0] BASE_ADDR = C_BASE_ADDR
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cpu_stb_i,
  input  logic              cpu_cyc_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [31:0]       cpu_adr_i,
  input  logic [31:0]       cpu_dat_i,
  output logic              cpu_ack_o,
  output logic [31:0]       cpu_dat_o,
  input  logic              dma_stb_i,
  input  logic              dma_cyc_i,
  input  logic              dma_we_i,
  input  logic [3:0]        dma_sel_i,
  input  logic [31:0]       dma_adr_i,
  input  logic [31:0]       dma_dat_i,
  output logic              dma_ack_o,
  output logic [31:0]       dma_dat_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  logic        w_cpu_req;
  logic        w_dma_req;
  logic        w_req_any;
  master_e     w_winner;
  logic [31:0] w_ack_dat;
  logic        w_unused;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  master_e           win_q, win_d;
  logic              rd_q, rd_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic [31:0]       cpu_dat_q, cpu_dat_d;
  logic [31:0]       dma_dat_q, dma_dat_d;
`ifdef WB_BRAM_ARB_RR_EN
  master_e           last_q, last_d;
`endif

  assign w_cpu_req = cpu_stb_i & cpu_cyc_i &
                     (cpu_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_dma_req = dma_stb_i & dma_cyc_i;
  assign w_unused  = ^{cpu_adr_i[1:0], dma_adr_i[31:ADDR_W+2], dma_adr_i[1:0]};

  wb_bram_arb_pick u_pick (
    .cpu_req_i    (w_cpu_req),
    .dma_req_i    (w_dma_req),
`ifdef WB_BRAM_ARB_RR_EN
    .last_grant_i (last_q),
`endif
    .req_any_o    (w_req_any),
    .winner_o     (w_winner)
  );

  // The BRAM read port is itself registered, so read data is forwarded
  // straight through in the ACK cycle and held in dat_q afterwards.
  assign w_ack_dat = rd_q ? mem_rdata_i : 32'h0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    rd_d        = rd_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'h0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_dat_d   = cpu_dat_q;
    dma_dat_d   = dma_dat_q;
`ifdef WB_BRAM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (w_req_any) begin
          state_d  = S_ISSUE;
          win_d    = w_winner;
          mem_en_d = 1'b1;
          if (w_winner == M_DMA) begin
            rd_d        = ~dma_we_i;
            mem_we_d    = dma_we_i ? dma_sel_i : 4'h0;
            mem_addr_d  = dma_adr_i[ADDR_W+1:2];
            mem_wdata_d = dma_dat_i;
          end else begin
            rd_d        = ~cpu_we_i;
            mem_we_d    = cpu_we_i ? cpu_sel_i : 4'h0;
            mem_addr_d  = cpu_adr_i[ADDR_W+1:2];
            mem_wdata_d = cpu_dat_i;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 4'(READ_LAT - 1);
        state_d = (READ_LAT == 1) ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (win_q == M_CPU) begin
          cpu_dat_d = w_ack_dat;
        end else begin
          dma_dat_d = w_ack_dat;
        end
`ifdef WB_BRAM_ARB_RR_EN
        last_d = win_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Ack flops rise on entry to ACK so the pulse lines up with the ACK cycle
    if (state_d == S_ACK) begin
      cpu_ack_d = (win_q == M_CPU);
      dma_ack_d = (win_q == M_DMA);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'h0;
      win_q       <= M_CPU;
      rd_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_dat_q   <= 32'h0;
      dma_dat_q   <= 32'h0;
`ifdef WB_BRAM_ARB_RR_EN
      last_q      <= M_CPU;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      rd_q        <= rd_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_dat_q   <= cpu_dat_d;
      dma_dat_q   <= dma_dat_d;
`ifdef WB_BRAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign cpu_dat_o   = cpu_ack_q ? w_ack_dat : cpu_dat_q;
  assign dma_dat_o   = dma_ack_q ? w_ack_dat : dma_dat_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_bram_arbiter.sv
// ============================================================================
// Module   : tb_wb_bram_arbiter
// Brief    : Directed self-checking bench for wb_bram_arbiter with a BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_bram_arbiter;
  import wb_bram_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int READ_LAT = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_stb = 1'b0, cpu_cyc = 1'b0, cpu_we = 1'b0;
  logic [3:0]        cpu_sel = 4'h0;
  logic [31:0]       cpu_adr = 32'h0, cpu_dat = 32'h0;
  logic              dma_stb = 1'b0, dma_cyc = 1'b0, dma_we = 1'b0;
  logic [3:0]        dma_sel = 4'h0;
  logic [31:0]       dma_adr = 32'h0, dma_dat = 32'h0;
  logic              cpu_ack_o, dma_ack_o, mem_en_o;
  logic [31:0]       cpu_dat_o, dma_dat_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_bram_arbiter #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .BASE_ADDR(32'h3800_0000)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cpu_stb_i   (cpu_stb),
    .cpu_cyc_i   (cpu_cyc),
    .cpu_we_i    (cpu_we),
    .cpu_sel_i   (cpu_sel),
    .cpu_adr_i   (cpu_adr),
    .cpu_dat_i   (cpu_dat),
    .cpu_ack_o   (cpu_ack_o),
    .cpu_dat_o   (cpu_dat_o),
    .dma_stb_i   (dma_stb),
    .dma_cyc_i   (dma_cyc),
    .dma_we_i    (dma_we),
    .dma_sel_i   (dma_sel),
    .dma_adr_i   (dma_adr),
    .dma_dat_i   (dma_dat),
    .dma_ack_o   (dma_ack_o),
    .dma_dat_o   (dma_dat_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // BRAM model: data read at an enable is visible READ_LAT cycles later
  logic [31:0]       mem  [1024];
  logic [31:0]       pipe [READ_LAT];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = 32'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_en_o) begin
      pipe[0] <= mem[mem_addr_o];
      for (int b = 0; b < 4; b++) begin
        if (mem_we_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
    for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata_i = pipe[READ_LAT-1];

  // Event monitor sampled on the falling edge
  int          cpu_ack_n = 0, dma_ack_n = 0, en_n = 0;
  int          cpu_ack_at = 0, dma_ack_at = 0;
  logic [31:0] cpu_dat_ack = 32'h0, dma_dat_ack = 32'h0;
  master_e     order  [64];
  int          ack_cyc[64];
  int          order_n = 0;

  always @(negedge clk) begin
    if (mem_en_o) en_n++;
    if (cpu_ack_o) begin
      cpu_ack_n++; cpu_ack_at = cyc; cpu_dat_ack = cpu_dat_o;
      if (order_n < 64) begin order[order_n] = M_CPU; ack_cyc[order_n] = cyc; order_n++; end
    end
    if (dma_ack_o) begin
      dma_ack_n++; dma_ack_at = cyc; dma_dat_ack = dma_dat_o;
      if (order_n < 64) begin order[order_n] = M_DMA; ack_cyc[order_n] = cyc; order_n++; end
    end
  end

  task automatic wait_acks(input int cpu_tgt, input int dma_tgt, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (cpu_ack_n >= cpu_tgt && dma_ack_n >= dma_tgt) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cpu_ack_o, dma_ack_o, mem_en_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ack_en: got %b want 000", {cpu_ack_o, dma_ack_o, mem_en_o});
    end
    n_checks++;
    if ({mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
      n_fail++; $display("FAIL reset_mem_bus: got we=%h addr=%h wdata=%h want 0", mem_we_o, mem_addr_o, mem_wdata_o);
    end
    n_checks++;
    if ({cpu_dat_o, dma_dat_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_dat: got cpu=%h dma=%h want 0", cpu_dat_o, dma_dat_o);
    end
    preload(10'h010, 32'hDEAD_BEEF);
    preload(10'h040, 32'hCAFE_0000);
    preload(10'h002, 32'hA5A5_0002);
    preload(10'h020, 32'h1111_2222);
    preload(10'h021, 32'h3333_4444);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (en_n !== 0) begin
      n_fail++; $display("FAIL reset_idle_en: got %0d enables want 0", en_n);
    end
  endtask

  task automatic test_cpu_read();
    int t, c0, d0, e0;
    bit ok;
    c0 = cpu_ack_n; d0 = dma_ack_n; e0 = en_n;
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 32'h3800_0040;
    t = cyc;
    @(negedge clk);
    n_checks++;
    if (mem_en_o !== 1'b0) begin
      n_fail++; $display("FAIL cpu_rd_en_early: got %b want 0", mem_en_o);
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en_o, mem_we_o, mem_addr_o} !== {1'b1, 4'h0, 10'h010}) begin
      n_fail++; $display("FAIL cpu_rd_issue: got en=%b we=%h addr=%h want en=1 we=0 addr=010", mem_en_o, mem_we_o, mem_addr_o);
    end
    wait_acks(c0 + 1, 0, 40, ok);
    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL cpu_rd_timeout: got no ack want ack");
    end
    n_checks++;
    if (cpu_ack_at - t !== 11) begin
      n_fail++; $display("FAIL cpu_rd_latency: got %0d want 11", cpu_ack_at - t);
    end
    n_checks++;
    if (cpu_dat_ack !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL cpu_rd_data_at_ack: got %h want deadbeef", cpu_dat_ack);
    end
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if (cpu_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL cpu_rd_data_hold: got %h want deadbeef", cpu_dat_o);
    end
    n_checks++;
    if ({cpu_ack_n - c0, dma_ack_n - d0, en_n - e0} !== {32'd1, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL cpu_rd_counts: got cpu=%0d dma=%0d en=%0d want 1 0 1", cpu_ack_n - c0, dma_ack_n - d0, en_n - e0);
    end
  endtask

  task automatic test_dma_write();
    int t, c0, d0;
    bit ok;
    c0 = cpu_ack_n; d0 = dma_ack_n;
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b1; dma_sel = 4'b0011;
    dma_adr = 32'h3800_0100; dma_dat = 32'h0000_1234;
    t = cyc;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'b0011, 10'h040, 32'h0000_1234}) begin
      n_fail++; $display("FAIL dma_wr_issue: got en=%b we=%b addr=%h wdata=%h want 1 0011 040 00001234", mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    wait_acks(0, d0 + 1, 40, ok);
    dma_stb = 1'b0; dma_cyc = 1'b0; dma_we = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || dma_ack_at - t !== 11) begin
      n_fail++; $display("FAIL dma_wr_ack: got ok=%b latency=%0d want 1 11", ok, dma_ack_at - t);
    end
    repeat (3) @(posedge clk); #1;
    n_checks++;
    if ({dma_ack_n - d0, cpu_ack_n - c0} !== {32'd1, 32'd0} || dma_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL dma_wr_single: got dma=%0d cpu=%0d dat=%h want 1 0 00000000", dma_ack_n - d0, cpu_ack_n - c0, dma_dat_o);
    end
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 32'h3800_0100;
    wait_acks(c0 + 1, 0, 40, ok);
    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || cpu_dat_o[15:0] !== 16'h1234) begin
      n_fail++; $display("FAIL dma_wr_readback_low: got ok=%b low=%h want 1 1234", ok, cpu_dat_o[15:0]);
    end
    n_checks++;
    if (cpu_dat_o !== 32'hCAFE_1234) begin
      n_fail++; $display("FAIL dma_wr_readback_full: got %h want cafe1234", cpu_dat_o);
    end
  endtask

  task automatic test_simultaneous();
    int t, c0, d0;
    bit ok;
    c0 = cpu_ack_n; d0 = dma_ack_n;
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 32'h3800_0040;
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b0; dma_sel = 4'hF; dma_adr = 32'h3800_0008;
    t = cyc;
    wait_acks(0, d0 + 1, 40, ok);
    dma_stb = 1'b0; dma_cyc = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || dma_ack_at - t !== 11 || cpu_ack_n !== c0) begin
      n_fail++; $display("FAIL sim_dma_first: got ok=%b lat=%0d cpu_acks=%0d want 1 11 0", ok, dma_ack_at - t, cpu_ack_n - c0);
    end
    n_checks++;
    if (dma_dat_o !== 32'hA5A5_0002) begin
      n_fail++; $display("FAIL sim_dma_data: got %h want a5a50002", dma_dat_o);
    end
    wait_acks(c0 + 1, 0, 40, ok);
    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || cpu_ack_at - t !== 23) begin
      n_fail++; $display("FAIL sim_cpu_second: got ok=%b lat=%0d want 1 23", ok, cpu_ack_at - t);
    end
    n_checks++;
    if (cpu_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sim_cpu_data: got %h want deadbeef", cpu_dat_o);
    end
  endtask

  task automatic test_back_to_back();
    int t, o0;
    bit ok;
    master_e exp [4];
`ifdef WB_BRAM_ARB_RR_EN
    exp[0] = M_DMA; exp[1] = M_CPU; exp[2] = M_DMA; exp[3] = M_CPU;
`else
    exp[0] = M_DMA; exp[1] = M_DMA; exp[2] = M_DMA; exp[3] = M_DMA;
`endif
    o0 = order_n;
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 32'h3800_0080;
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b0; dma_sel = 4'hF; dma_adr = 32'h3800_0084;
    t = cyc;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      if (order_n >= o0 + 4) begin ok = 1'b1; break; end
    end
    #1;
    cpu_stb = 1'b0; cpu_cyc = 1'b0; dma_stb = 1'b0; dma_cyc = 1'b0;
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL b2b_timeout: got %0d acks want 4", order_n - o0);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (order[o0+i] !== exp[i]) begin
        n_fail++; $display("FAIL b2b_grant%0d: got %0d want %0d (0=cpu 1=dma)", i, order[o0+i], exp[i]);
      end
    end
    n_checks++;
    if (ack_cyc[o0] - t !== 11 || ack_cyc[o0+3] - ack_cyc[o0] !== 3 * (READ_LAT + 2)) begin
      n_fail++; $display("FAIL b2b_spacing: got first=%0d span=%0d want 11 36", ack_cyc[o0] - t, ack_cyc[o0+3] - ack_cyc[o0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_window();
    int t, c0, d0, e0;
    bit ok;
    c0 = cpu_ack_n; d0 = dma_ack_n; e0 = en_n;
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 32'h3000_0000;
    repeat (20) @(posedge clk); #1;
    n_checks++;
    if (en_n - e0 !== 0 || cpu_ack_n - c0 !== 0) begin
      n_fail++; $display("FAIL oow_ignored: got en=%0d ack=%0d want 0 0", en_n - e0, cpu_ack_n - c0);
    end
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b0; dma_sel = 4'hF; dma_adr = 32'h3800_0008;
    t = cyc;
    wait_acks(0, d0 + 1, 40, ok);
    dma_stb = 1'b0; dma_cyc = 1'b0;
    repeat (3) @(posedge clk); #1;
    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || dma_ack_at - t !== 11 || dma_dat_o !== 32'hA5A5_0002) begin
      n_fail++; $display("FAIL oow_dma_served: got ok=%b lat=%0d dat=%h want 1 11 a5a50002", ok, dma_ack_at - t, dma_dat_o);
    end
    n_checks++;
    if (en_n - e0 !== 1 || cpu_ack_n - c0 !== 0) begin
      n_fail++; $display("FAIL oow_counts: got en=%0d cpu_ack=%0d want 1 0", en_n - e0, cpu_ack_n - c0);
    end
  endtask

  task automatic test_reset_mid();
    int t, c0, d0;
    bit ok;
    c0 = cpu_ack_n; d0 = dma_ack_n;
    dma_cyc = 1'b1; dma_stb = 1'b1; dma_we = 1'b0; dma_sel = 4'hF; dma_adr = 32'h3800_0040;
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dma_ack_o, cpu_ack_o, mem_en_o, mem_we_o, mem_addr_o} !== '0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got ack=%b%b en=%b we=%h addr=%h want 0", dma_ack_o, cpu_ack_o, mem_en_o, mem_we_o, mem_addr_o);
    end
    n_checks++;
    if ({cpu_dat_o, dma_dat_o, mem_wdata_o} !== 96'h0) begin
      n_fail++; $display("FAIL rst_mid_data: got cpu=%h dma=%h wdata=%h want 0", cpu_dat_o, dma_dat_o, mem_wdata_o);
    end
    dma_stb = 1'b0; dma_cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk); #1;
    n_checks++;
    if (dma_ack_n - d0 !== 0) begin
      n_fail++; $display("FAIL rst_mid_no_ack: got %0d dma acks want 0", dma_ack_n - d0);
    end
    cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_adr = 32'h3800_0040;
    t = cyc;
    wait_acks(c0 + 1, 0, 40, ok);
    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || cpu_ack_at - t !== READ_LAT + 1 || cpu_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rst_mid_recover: got ok=%b lat=%0d dat=%h want 1 %0d deadbeef", ok, cpu_ack_at - t, cpu_dat_o, READ_LAT + 1);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_back_to_back();
    test_out_of_window();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
